// File: rtl/sap_microsequencer.sv
// sap_microsequencer
// Ring-counter control unit for the 8-bit SAP datapath. It steps the T-states
// T1..T_LAST and decodes the IR opcode into the per-state control word. That
// control word is made up of the register loads, the bus source select, the
// memory write and the ALU mode.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   reg_clr  synchronous active-high reset (highest priority)
//   en       run enable; low freezes T and forces every strobe off
//   opcode   IR[6:4], only looked at in T4..T6
//   step     single-step request (only meaningful with SAP_SINGLE_STEP_EN)
//   inc_PC, ld_MAR, ld_IR, ld_ACC, ld_Breg, ld_out   datapath strobes
//   ld_bus   bus source: 0=PC 1=memory 2=IR 3=ACC 4=ALU 7=none
//   mem_wr   memory write at the MAR address
//   cin, sum, tx   ALU controls (subtract, add path, drive result)
//   T        current T-state 1..T_LAST, 0 while halted or paused
//   halted   high once an HLT has retired
//
// Optional feature macro: SAP_SINGLE_STEP_EN. When it is defined, the sequencer
// parks in PAUSE after every instruction and waits for a rising edge of step.
// When it is not defined, step is ignored and T wraps from T_LAST to T1.

module sap_microsequencer #(
    parameter int OPCODE_W = 3,
    parameter int SEL_W    = 3,
    parameter int T_LAST   = 6
) (
    input  logic                clk,
    input  logic                reg_clr,
    input  logic                en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                step,
    output logic                inc_PC,
    output logic                ld_MAR,
    output logic                ld_IR,
    output logic                ld_ACC,
    output logic                ld_Breg,
    output logic                ld_out,
    output logic [SEL_W-1:0]    ld_bus,
    output logic                mem_wr,
    output logic                cin,
    output logic                sum,
    output logic                tx,
    output logic [2:0]          T,
    output logic                halted
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_PAUSE
    } state_t;

    localparam logic [2:0] T_FIRST = 3'd1;
    localparam logic [2:0] T_END   = 3'(T_LAST);

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(7);

    localparam logic [SEL_W-1:0] BUS_PC   = SEL_W'(0);
    localparam logic [SEL_W-1:0] BUS_MEM  = SEL_W'(1);
    localparam logic [SEL_W-1:0] BUS_IR   = SEL_W'(2);
    localparam logic [SEL_W-1:0] BUS_ACC  = SEL_W'(3);
    localparam logic [SEL_W-1:0] BUS_ALU  = SEL_W'(4);
    localparam logic [SEL_W-1:0] BUS_NONE = SEL_W'(7);

    state_t     state_q, state_d;
    logic [2:0] t_q, t_d;
    logic       active;

`ifdef SAP_SINGLE_STEP_EN
    // The previous step level is tracked even while en is low. A press made
    // while disabled therefore looks "already high" later and is not queued.
    logic stepPrev_q;
    logic stepRise;

    always_ff @(posedge clk) begin
        if (reg_clr) stepPrev_q <= 1'b0;
        else         stepPrev_q <= step;
    end

    assign stepRise = step & ~stepPrev_q;
`else
    logic unusedStep;
    assign unusedStep = step;
`endif

    always_ff @(posedge clk) begin
        if (reg_clr) begin
            state_q <= ST_RUN;
            t_q     <= T_FIRST;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // HALT and PAUSE both park T at 0, so T is simply the register.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        if (en) begin
            case (state_q)
                ST_RUN: begin
                    if (t_q == 3'd4 && opcode == OP_HLT) begin
                        state_d = ST_HALT;
                        t_d     = 3'd0;
                    end else if (t_q == T_END) begin
`ifdef SAP_SINGLE_STEP_EN
                        state_d = ST_PAUSE;
                        t_d     = 3'd0;
`else
                        t_d     = T_FIRST;
`endif
                    end else begin
                        t_d = t_q + 3'd1;
                    end
                end
`ifdef SAP_SINGLE_STEP_EN
                ST_PAUSE: begin
                    if (stepRise) begin
                        state_d = ST_RUN;
                        t_d     = T_FIRST;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Strobes are also gated by reg_clr. A reset cycle therefore never lets a
    // half-finished instruction load a register at the same edge.
    assign active = en && !reg_clr && (state_q == ST_RUN);

    always_comb begin
        inc_PC  = 1'b0;
        ld_MAR  = 1'b0;
        ld_IR   = 1'b0;
        ld_ACC  = 1'b0;
        ld_Breg = 1'b0;
        ld_out  = 1'b0;
        ld_bus  = BUS_NONE;
        mem_wr  = 1'b0;
        cin     = 1'b0;
        sum     = 1'b0;
        tx      = 1'b0;
        T       = t_q;
        halted  = (state_q == ST_HALT);
        if (active) begin
            case (t_q)
                3'd1: begin
                    ld_bus = BUS_PC;
                    ld_MAR = 1'b1;
                end
                3'd2: inc_PC = 1'b1;
                3'd3: begin
                    ld_bus = BUS_MEM;
                    ld_IR  = 1'b1;
                end
                3'd4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ld_bus = BUS_IR;
                            ld_MAR = 1'b1;
                        end
                        OP_OUT: begin
                            ld_bus = BUS_ACC;
                            ld_out = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd5: begin
                    case (opcode)
                        OP_LDA: begin
                            ld_bus = BUS_MEM;
                            ld_ACC = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ld_bus  = BUS_MEM;
                            ld_Breg = 1'b1;
                        end
                        OP_STA: begin
                            ld_bus = BUS_ACC;
                            mem_wr = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        sum    = 1'b1;
                        tx     = 1'b1;
                        cin    = (opcode == OP_SUB);
                        ld_bus = BUS_ALU;
                        ld_ACC = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_microsequencer.sv
// tb_sap_microsequencer
// Directed bench for sap_microsequencer. Inputs are set about 1ns after a rising
// edge. Outputs are read after a further 1ns, well clear of the next edge.
// Expected control words are hand-built constants. The bit order is
// {inc_PC, ld_MAR, ld_IR, ld_ACC, ld_Breg, ld_out, ld_bus[2:0], mem_wr, cin, sum, tx}.

module tb_sap_microsequencer;

    logic       clk = 1'b0;
    logic       reg_clr, en, step;
    logic [2:0] opcode;
    logic       inc_PC, ld_MAR, ld_IR, ld_ACC, ld_Breg, ld_out;
    logic [2:0] ld_bus;
    logic       mem_wr, cin, sum, tx;
    logic [2:0] T;
    logic       halted;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [12:0] CW_IDLE   = {6'b000000, 3'd7, 4'b0000};
    localparam logic [12:0] CW_T1     = {6'b010000, 3'd0, 4'b0000};
    localparam logic [12:0] CW_T2     = {6'b100000, 3'd7, 4'b0000};
    localparam logic [12:0] CW_T3     = {6'b001000, 3'd1, 4'b0000};
    localparam logic [12:0] CW_MAR_IR = {6'b010000, 3'd2, 4'b0000};
    localparam logic [12:0] CW_LDA5   = {6'b000100, 3'd1, 4'b0000};
    localparam logic [12:0] CW_B5     = {6'b000010, 3'd1, 4'b0000};
    localparam logic [12:0] CW_ADD6   = {6'b000100, 3'd4, 4'b0011};
    localparam logic [12:0] CW_SUB6   = {6'b000100, 3'd4, 4'b0111};
    localparam logic [12:0] CW_STA5   = {6'b000000, 3'd3, 4'b1000};
    localparam logic [12:0] CW_OUT4   = {6'b000001, 3'd3, 4'b0000};

    logic [12:0] cwObs;
    assign cwObs = {inc_PC, ld_MAR, ld_IR, ld_ACC, ld_Breg, ld_out,
                    ld_bus, mem_wr, cin, sum, tx};

    sap_microsequencer dut (
        .clk     (clk),
        .reg_clr (reg_clr),
        .en      (en),
        .opcode  (opcode),
        .step    (step),
        .inc_PC  (inc_PC),
        .ld_MAR  (ld_MAR),
        .ld_IR   (ld_IR),
        .ld_ACC  (ld_ACC),
        .ld_Breg (ld_Breg),
        .ld_out  (ld_out),
        .ld_bus  (ld_bus),
        .mem_wr  (mem_wr),
        .cin     (cin),
        .sum     (sum),
        .tx      (tx),
        .T       (T),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    // Drive all inputs and let the combinational controls settle.
    task automatic applyStimulus(input logic clr, input logic e,
                                 input logic s, input logic [2:0] op);
        reg_clr = clr;
        en      = e;
        step    = s;
        opcode  = op;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkStep(input string tag, input logic [2:0] expT,
                             input logic [12:0] expCw);
        checkOutput({tag, ".T"}, 32'(T), 32'(expT));
        checkOutput({tag, ".cw"}, 32'(cwObs), 32'(expCw));
    endtask

    // One clock, then the load-exclusivity invariant on the new state.
    task automatic clockCycle();
        @(posedge clk);
        #1;
        checkOutput("oneHotLoads",
                    32'(($countones({ld_MAR, ld_IR, ld_ACC, ld_Breg, ld_out}) <= 1)
                        && !(mem_wr && ld_MAR)), 32'd1);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
        clockCycle();
        checkStep("reset", 3'd1, CW_IDLE);
        checkOutput("reset.halted", 32'(halted), 32'd0);

        // LDA: full ring 1..6 and wrap.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
        checkStep("lda.T1", 3'd1, CW_T1);
        clockCycle(); checkStep("lda.T2", 3'd2, CW_T2);
        clockCycle(); checkStep("lda.T3", 3'd3, CW_T3);
        clockCycle(); checkStep("lda.T4", 3'd4, CW_MAR_IR);
        clockCycle(); checkStep("lda.T5", 3'd5, CW_LDA5);
        clockCycle(); checkStep("lda.T6", 3'd6, CW_IDLE);
        clockCycle(); checkStep("lda.wrap", 3'd1, CW_T1);

        // SUB
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2);
        clockCycle(); clockCycle(); clockCycle();
        checkStep("sub.T4", 3'd4, CW_MAR_IR);
        clockCycle(); checkStep("sub.T5", 3'd5, CW_B5);
        clockCycle(); checkStep("sub.T6", 3'd6, CW_SUB6);
        clockCycle();

        // ADD
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd1);
        clockCycle(); clockCycle(); clockCycle();
        checkStep("add.T4", 3'd4, CW_MAR_IR);
        clockCycle(); checkStep("add.T5", 3'd5, CW_B5);
        clockCycle(); checkStep("add.T6", 3'd6, CW_ADD6);
        clockCycle();

        // STA
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd3);
        clockCycle(); clockCycle(); clockCycle();
        checkStep("sta.T4", 3'd4, CW_MAR_IR);
        clockCycle(); checkStep("sta.T5", 3'd5, CW_STA5);
        clockCycle(); checkStep("sta.T6", 3'd6, CW_IDLE);
        clockCycle();

        // OUT
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd4);
        clockCycle(); clockCycle(); clockCycle();
        checkStep("out.T4", 3'd4, CW_OUT4);
        clockCycle(); checkStep("out.T5", 3'd5, CW_IDLE);
        clockCycle(); checkStep("out.T6", 3'd6, CW_IDLE);
        clockCycle();

        // NOP (opcode 5)
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd5);
        clockCycle(); clockCycle(); clockCycle();
        checkStep("nop.T4", 3'd4, CW_IDLE);
        clockCycle(); checkStep("nop.T5", 3'd5, CW_IDLE);
        clockCycle(); checkStep("nop.T6", 3'd6, CW_IDLE);
        clockCycle(); checkStep("nop.wrap", 3'd1, CW_T1);

        // en dropped at T2 for three cycles.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
        clockCycle(); checkStep("en.T2", 3'd2, CW_T2);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        checkStep("en.off", 3'd2, CW_IDLE);
        for (int i = 0; i < 3; i++) begin
            clockCycle(); checkStep("en.hold", 3'd2, CW_IDLE);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
        checkStep("en.back", 3'd2, CW_T2);
        clockCycle(); checkStep("en.T3", 3'd3, CW_T3);
        clockCycle(); clockCycle(); checkStep("en.T5", 3'd5, CW_LDA5);

        // Reset at T5: no ACC load, restart at T1.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0);
        checkStep("clrT5.during", 3'd5, CW_IDLE);
        clockCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
        checkStep("clrT5.after", 3'd1, CW_T1);

        // HLT
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd7);
        clockCycle(); clockCycle(); clockCycle();
        checkStep("hlt.T4", 3'd4, CW_IDLE);
        clockCycle();
        checkStep("hlt.halt", 3'd0, CW_IDLE);
        checkOutput("hlt.halted", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            clockCycle();
            checkOutput("hlt.frozen", 32'({halted, T, cwObs}),
                        32'({1'b1, 3'd0, CW_IDLE}));
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd7);
        clockCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
        checkStep("hlt.clr", 3'd1, CW_T1);
        checkOutput("hlt.clrHalted", 32'(halted), 32'd0);

        // Run one LDA up to T6.
        for (int i = 0; i < 5; i++) clockCycle();
        checkStep("ring.T6", 3'd6, CW_IDLE);
        clockCycle();

`ifdef SAP_SINGLE_STEP_EN
        for (int i = 0; i < 10; i++) begin
            checkOutput("pause.idle", 32'({halted, T, cwObs}),
                        32'({1'b0, 3'd0, CW_IDLE}));
            clockCycle();
        end
        // A step press while disabled is dropped, and holding it
        // afterwards is not a new edge.
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd0);
        clockCycle(); checkStep("pause.enOff", 3'd0, CW_IDLE);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd0);
        clockCycle(); checkStep("pause.heldNoEdge", 3'd0, CW_IDLE);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
        clockCycle();
        // A single-cycle pulse runs exactly one instruction.
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd0);
        clockCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
        checkStep("step.T1", 3'd1, CW_T1);
        for (int i = 2; i <= 6; i++) begin
            clockCycle();
            checkOutput("step.T", 32'(T), 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            clockCycle();
            checkStep("step.repause", 3'd0, CW_IDLE);
        end
        // Holding step high still gives only one instruction.
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd0);
        clockCycle(); checkStep("hold.T1", 3'd1, CW_T1);
        for (int i = 0; i < 5; i++) clockCycle();
        checkStep("hold.T6", 3'd6, CW_IDLE);
        clockCycle(); clockCycle();
        checkStep("hold.repause", 3'd0, CW_IDLE);
`else
        checkStep("ring.wrap", 3'd1, CW_T1);
        // step is ignored; T keeps counting whatever it does.
        for (int i = 2; i <= 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'(i % 2), 3'd0);
            clockCycle();
            checkOutput("ring.stepIgnored", 32'(T), 32'(i));
        end
        clockCycle();
        checkStep("ring.wrap2", 3'd1, CW_T1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sap_microsequencer.md
Name: sap_microsequencer

Overview:
- Ring-counter microsequencer for the 8-bit SAP datapath (PC, MAR, IR, ACC, B, OUT register, shared 8-bit bus, synchronous 16x8 memory, adder/subtractor).
- Steps T-states T1..T6 and decodes the IR opcode into a per-state control word (register loads, bus source select, memory write, ALU mode).
- Adds STA, NOP and a latched halt on top of LDA/ADD/SUB/OUT/HLT.
- Sits between the IR and every datapath load/select input. It is the only driver of those controls.

Parameters:
- OPCODE_W, 3, opcode width (IR[6:4]).
- SEL_W, 3, bus source select width.
- T_LAST, 6, final T-state of every instruction (ring length).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reg_clr  input  1  synchronous, active-high reset.
- en  input  1  run enable; low freezes the sequencer.
- opcode  input  OPCODE_W  IR[6:4]; sampled only in T4..T6.
- step  input  1  single-step request (used only with the optional feature).
- inc_PC  output  1  PC increment.
- ld_MAR, ld_IR, ld_ACC, ld_Breg, ld_out  output  1 each  register load strobes.
- ld_bus  output  SEL_W  bus source: 0=PC, 1=memory, 2=IR, 3=ACC, 4=ALU, 7=none.
- mem_wr  output  1  memory write at MAR address.
- cin, sum, tx  output  1 each  ALU controls: sum=1 selects the add path; cin=1 inverts B and adds 1 (subtract); tx=1 drives the ALU result.
- T  output  3  current T-state 1..6; 0 when halted/paused.
- halted  output  1  high after an HLT retires.

Behaviour:
- Reset: on a clk edge with reg_clr=1, state=RUN, T=1, halted=0. All loads, inc_PC and mem_wr are 0 and ld_bus=7 until the first enabled cycle.
- Reset takes priority over en, step and HLT, including mid-instruction and while HALT.
- Controls are combinational from the registered state (T, mode) plus opcode. No extra latency: a strobe asserted in Tn takes effect at the edge ending Tn.
- en=0: T holds, all strobes are 0, ld_bus=7.
- en=1 in RUN: T advances 1→2→…→T_LAST→1 each cycle.
- Fetch, identical for all opcodes:
  - T1: ld_bus=0, ld_MAR.
  - T2: inc_PC.
  - T3: ld_bus=1, ld_IR.
- Execute (T4/T5/T6):
  - 0 LDA: T4 ld_bus=2, ld_MAR; T5 ld_bus=1, ld_ACC; T6 idle.
  - 1 ADD: T4 ld_bus=2, ld_MAR; T5 ld_bus=1, ld_Breg; T6 sum=1, tx=1, ld_bus=4, ld_ACC.
  - 2 SUB: as ADD, with cin=1 in T6.
  - 3 STA: T4 ld_bus=2, ld_MAR; T5 ld_bus=3, mem_wr; T6 idle.
  - 4 OUT: T4 ld_bus=3, ld_out; T5/T6 idle.
  - 5, 6 NOP: T4..T6 idle.
  - 7 HLT: at the T4 edge go to HALT.
- Idle means all strobes 0, ld_bus=7, cin=sum=tx=0.
- HALT: T=0, halted=1, all strobes 0. Leaves only via reg_clr.
- At most one ld_* strobe is high in any cycle. mem_wr is never high together with ld_MAR.

Optional Feature:
- Macro: SAP_SINGLE_STEP_EN.
- Defined:
  - After T_LAST the sequencer enters PAUSE: T=0, strobes 0, halted=0.
  - A rising edge of step (step=1 in the current cycle, 0 in the previous) returns it to T1 on the next edge.
  - Holding step high advances exactly one instruction.
  - A step pulse with en=0 is ignored; it is not queued.
- Not defined: the step port is present but ignored, and T_LAST wraps directly to T1.

Test Plan:
- Reset, en=1, opcode=0: T runs 1,2,3,4,5,6,1. T1 ld_MAR & ld_bus=0; T3 ld_IR & ld_bus=1; T5 ld_ACC & ld_bus=1.
- SUB in T4..T6: T5 ld_Breg; T6 sum=1, cin=1, tx=1, ld_bus=4, ld_ACC=1. ADD gives the same but with cin=0.
- STA then OUT: STA T5 has mem_wr=1, ld_bus=3. OUT T4 has ld_out=1, ld_bus=3. Check the one-hot load invariant every cycle.
- HLT: after the T4 edge T=0 and halted=1. Further 20 cycles with en=1 stay frozen. reg_clr=1 for one cycle gives T=1, halted=0.
- en dropped at T2 for 3 cycles: T stays 2 and inc_PC=0 throughout. Re-enable → T=3 next. reg_clr asserted at T5 → next T=1, no ld_ACC.
- With SAP_SINGLE_STEP_EN: after T6, T=0 for 10 cycles. A 1-cycle step pulse → exactly T1..T6, then T=0 again.
